// File: rtl/pwm_bank.sv
// pwm_bank -- multi-channel PWM generator with a shared period counter.
//
// Every channel compares the shared period counter against its own active
// duty value. Writes land in a per-channel shadow register and are committed
// only at the period boundary, so an output never sees a partial period with
// a mixed duty. A channel in fade mode ramps its duty up and down by
// FADE_STEP once per period, holding each clamped endpoint for one period.
//
// Parameters:
//   CHANNELS     number of PWM outputs (>= 1)
//   PWM_INTERVAL period length in clk cycles (>= 2)
//   FADE_STEP    duty change per period in fade mode (1..PWM_INTERVAL)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   wr_en         write strobe, one write per cycle while high
//   wr_ch         target channel (indices >= CHANNELS are ignored)
//   wr_duty       duty value, or the starting duty in fade mode
//   wr_mode       0 = static, 1 = fade
//   pwm_out       PWM outputs, bit i belongs to channel i
//   period_start  one-cycle pulse in the first cycle of each period
//   pending       bit i high while channel i holds an uncommitted write
//
// pwm_out and period_start are registered and trail the counter by one cycle.

module pwm_bank #(
  parameter  int CHANNELS     = 3,
  parameter  int PWM_INTERVAL = 1200,
  parameter  int FADE_STEP    = 12,
  localparam int W            = $clog2(PWM_INTERVAL + 1),
  localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [W-1:0]        wr_duty,
  input  logic                wr_mode,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic [CHANNELS-1:0] pending
);

  localparam int CNTW = $clog2(PWM_INTERVAL);

  localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(PWM_INTERVAL - 1);
  localparam logic [W-1:0]    LIMIT      = W'(PWM_INTERVAL);
  localparam logic [W:0]      LIMIT_WIDE = (W + 1)'(PWM_INTERVAL);
  localparam logic [W-1:0]    STEP       = W'(FADE_STEP);
  localparam logic [W:0]      STEP_WIDE  = (W + 1)'(FADE_STEP);

  // ---------------------------------------------------------------------------
  // Shared period counter
  // ---------------------------------------------------------------------------
  logic [CNTW-1:0] cnt_reg;
  logic            period_start_reg;
  logic            boundary;
  logic [W-1:0]    cnt_ext;

  assign boundary = (cnt_reg == CNT_LAST);
  assign cnt_ext  = W'(cnt_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= boundary ? '0 : cnt_reg + CNTW'(1);
      period_start_reg <= boundary;
    end
  end

  assign period_start = period_start_reg;

  // Out-of-range duty values saturate at a full-on period.
  logic [W-1:0] wr_duty_clamped;
  assign wr_duty_clamped = (wr_duty > LIMIT) ? LIMIT : wr_duty;

  // ---------------------------------------------------------------------------
  // Per-channel shadow/active state
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [W-1:0] duty_reg;
    logic [W-1:0] sh_duty_reg;
    logic         mode_reg;
    logic         sh_mode_reg;
    logic         dir_reg;
    logic         pending_reg;
    logic         pwm_reg;
    logic         wr_hit;
    logic [W:0]   up_sum;
    logic [W-1:0] duty_next;
    logic         dir_next;

    // Only indices that exist can match, so wr_ch >= CHANNELS hits nothing.
    assign wr_hit = wr_en && (wr_ch == CW'(gi));

    // Next fade step, evaluated one bit wider so the upward sum cannot wrap.
    always_comb begin
      up_sum    = {1'b0, duty_reg} + STEP_WIDE;
      duty_next = duty_reg;
      dir_next  = dir_reg;
      if (!dir_reg) begin
        if (up_sum >= LIMIT_WIDE) begin
          duty_next = LIMIT;
          dir_next  = 1'b1;
        end else begin
          duty_next = up_sum[W-1:0];
        end
      end else begin
        if ({1'b0, duty_reg} <= STEP_WIDE) begin
          duty_next = '0;
          dir_next  = 1'b0;
        end else begin
          duty_next = duty_reg - STEP;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_reg    <= '0;
        sh_duty_reg <= '0;
        mode_reg    <= 1'b0;
        sh_mode_reg <= 1'b0;
        dir_reg     <= 1'b0;
        pending_reg <= 1'b0;
        pwm_reg     <= 1'b0;
      end else begin
        if (wr_hit) begin
          sh_duty_reg <= wr_duty_clamped;
          sh_mode_reg <= wr_mode;
        end

        // A write arriving in the boundary cycle itself is deferred to the
        // next boundary; the active state then behaves as if nothing pended.
        if (boundary && pending_reg && !wr_hit) begin
          duty_reg <= sh_duty_reg;
          mode_reg <= sh_mode_reg;
          dir_reg  <= 1'b0;
        end else if (boundary && mode_reg) begin
          duty_reg <= duty_next;
          dir_reg  <= dir_next;
        end

        if (wr_hit) begin
          pending_reg <= 1'b1;
        end else if (boundary) begin
          pending_reg <= 1'b0;
        end

        // duty 0 never matches, duty PWM_INTERVAL always matches.
        pwm_reg <= (cnt_ext < duty_reg);
      end
    end

    assign pwm_out[gi] = pwm_reg;
    assign pending[gi] = pending_reg;
  end

endmodule
